// File: rtl/layer_ctrl_tiled.sv
// Layer controller for a tiled convolution engine. It loads the IFM once, then for each
// output-channel tile it loads weights, runs compute and stores the OFM slice.
module layer_ctrl_tiled #(
    parameter int TOTAL_PE   = 16,
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        cfg_KERNEL_W,
    input  logic [7:0]        cfg_IFM_W,
    input  logic [7:0]        cfg_IFM_C,
    input  logic [7:0]        cfg_OFM_W,
    input  logic [7:0]        cfg_OFM_C,
    input  logic [1:0]        cfg_stride,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [ADDR_W-1:0] ofm_base,
    output logic              ifm_req,
    output logic [ADDR_W-1:0] ifm_addr,
    input  logic              ifm_ack,
    output logic              wgt_req,
    output logic [ADDR_W-1:0] wgt_addr,
    input  logic              wgt_ack,
    output logic              st_req,
    output logic [ADDR_W-1:0] st_addr,
    input  logic              st_ack,
    output logic              cal_start,
    input  logic              done_compute,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state,
    output logic [7:0]        tile_idx
);

    // Beat handshake: a request holds req high with a stable addr until ack is seen;
    // the beat completes on the cycle where req && ack are both high.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_CHECK = 3'd1, S_LOAD_IFM = 3'd2, S_LOAD_W = 3'd3,
        S_CAL  = 3'd4, S_STORE = 3'd5, S_NEXT     = 3'd6, S_DONE   = 3'd7
    } state_t;

    localparam int SHIFT = $clog2(DATA_BYTES);
    localparam logic [CNT_W-1:0] DB_MASK = CNT_W'(DATA_BYTES - 1);

    state_t            state_r, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        tile_r;
    logic              err_r;
    logic [3:0]        k_r;
    logic [7:0]        iw_r, ic_r, ow_r, oc_r;
    logic [1:0]        s_r;
    logic [ADDR_W-1:0] ib_r, wb_r, ob_r;

    logic              cnt_inc, tile_inc, tile_clr, err_nxt, latch;
    logic [CNT_W-1:0]  ifm_bytes, wgt_bytes, ofm_bytes;
    logic [CNT_W-1:0]  ifm_words, wgt_words, ofm_words, num_tiles;
    logic [1:0]        s_div;
    logic [8:0]        exp_ow;
    logic              cfg_bad, last_tile;

    function automatic logic [CNT_W-1:0] ceil_words(input logic [CNT_W-1:0] bytes);
        ceil_words = (bytes >> SHIFT) + CNT_W'(|(bytes & DB_MASK));
    endfunction

    assign ifm_bytes = CNT_W'(iw_r) * CNT_W'(iw_r) * CNT_W'(ic_r);
    assign wgt_bytes = CNT_W'(k_r) * CNT_W'(k_r) * CNT_W'(ic_r) * CNT_W'(TOTAL_PE);
    assign ofm_bytes = CNT_W'(ow_r) * CNT_W'(ow_r) * CNT_W'(TOTAL_PE);
    assign ifm_words = ceil_words(ifm_bytes);
    assign wgt_words = ceil_words(wgt_bytes);
    assign ofm_words = ceil_words(ofm_bytes);
    assign num_tiles = (CNT_W'(oc_r) + CNT_W'(TOTAL_PE - 1)) / CNT_W'(TOTAL_PE);
    assign last_tile = (CNT_W'(tile_r) == num_tiles - CNT_W'(1));

    // Stride 0 is already rejected; the substitute divisor only keeps the divide defined.
    assign s_div   = (s_r == 2'd0) ? 2'd1 : s_r;
    assign exp_ow  = {1'b0, (iw_r - {4'b0, k_r}) / {6'b0, s_div}} + 9'd1;
    assign cfg_bad = (k_r == 4'd0) || (iw_r == 8'd0) || (ic_r == 8'd0) || (ow_r == 8'd0) ||
                     (oc_r == 8'd0) || (s_r == 2'd0) || ({4'b0, k_r} > iw_r) ||
                     ({1'b0, ow_r} != exp_ow);

    always_comb begin
        state_nxt = state_r;
        cnt_inc   = 1'b0;
        tile_inc  = 1'b0;
        tile_clr  = 1'b0;
        err_nxt   = 1'b0;
        latch     = 1'b0;
        if (state_r != S_IDLE && abort) begin
            state_nxt = S_IDLE;
            tile_clr  = 1'b1;
        end else begin
            case (state_r)
                S_IDLE: if (start) begin
                    latch     = 1'b1;
                    state_nxt = S_CHECK;
                end
                S_CHECK: if (cfg_bad) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_LOAD_IFM;
                end
                S_LOAD_IFM: if (ifm_ack) begin
                    if (cnt == ifm_words - CNT_W'(1)) state_nxt = S_LOAD_W;
                    else                              cnt_inc   = 1'b1;
                end
                S_LOAD_W: if (wgt_ack) begin
                    if (cnt == wgt_words - CNT_W'(1)) state_nxt = S_CAL;
                    else                              cnt_inc   = 1'b1;
                end
                // cnt marks the first CAL cycle; done_compute is ignored until it is set.
                S_CAL: if (cnt == '0)      cnt_inc   = 1'b1;
                       else if (done_compute) state_nxt = S_STORE;
                S_STORE: if (st_ack) begin
                    if (cnt == ofm_words - CNT_W'(1)) state_nxt = S_NEXT;
                    else                              cnt_inc   = 1'b1;
                end
                S_NEXT: if (last_tile) begin
                    state_nxt = S_DONE;
                end else begin
                    tile_inc  = 1'b1;
                    state_nxt = S_LOAD_W;
                end
                S_DONE: begin
                    tile_clr  = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt     <= '0;
            tile_r  <= '0;
            err_r   <= 1'b0;
            k_r     <= '0;
            iw_r    <= '0;
            ic_r    <= '0;
            ow_r    <= '0;
            oc_r    <= '0;
            s_r     <= '0;
            ib_r    <= '0;
            wb_r    <= '0;
            ob_r    <= '0;
        end else begin
            state_r <= state_nxt;
            err_r   <= err_nxt;
            if (state_nxt != state_r) cnt <= '0;
            else if (cnt_inc)         cnt <= cnt + 1'b1;
            if (tile_clr)      tile_r <= '0;
            else if (tile_inc) tile_r <= tile_r + 8'd1;
            if (latch) begin
                k_r  <= cfg_KERNEL_W;
                iw_r <= cfg_IFM_W;
                ic_r <= cfg_IFM_C;
                ow_r <= cfg_OFM_W;
                oc_r <= cfg_OFM_C;
                s_r  <= cfg_stride;
                ib_r <= ifm_base;
                wb_r <= wgt_base;
                ob_r <= ofm_base;
            end
        end
    end

    assign ifm_req   = (state_r == S_LOAD_IFM);
    assign wgt_req   = (state_r == S_LOAD_W);
    assign st_req    = (state_r == S_STORE);
    assign ifm_addr  = ifm_req ? ib_r + ADDR_W'(cnt) : '0;
    assign wgt_addr  = wgt_req ? wb_r + ADDR_W'(tile_r) * ADDR_W'(wgt_words) + ADDR_W'(cnt) : '0;
    assign st_addr   = st_req  ? ob_r + ADDR_W'(tile_r) * ADDR_W'(ofm_words) + ADDR_W'(cnt) : '0;
    assign cal_start = (state_r == S_CAL) && (cnt == '0);
    assign busy      = (state_r != S_IDLE);
    assign done      = (state_r == S_DONE);
    assign err       = err_r;
    assign state     = state_r;
    assign tile_idx  = tile_r;

endmodule

// File: tb/tb_layer_ctrl_tiled.sv
// Bench for layer_ctrl_tiled: a reference model expands each layer into its expected beat
// and event stream; a negedge monitor pops and compares every observed beat or event.
module tb_layer_ctrl_tiled;

    localparam int PE = 16;
    localparam int DB = 4;
    localparam int EW = 42;  // {kind[1:0], tile[7:0], addr[31:0]}

    logic        clk, rst_n, start, abort;
    logic [3:0]  cfg_KERNEL_W;
    logic [7:0]  cfg_IFM_W, cfg_IFM_C, cfg_OFM_W, cfg_OFM_C;
    logic [1:0]  cfg_stride;
    logic [31:0] ifm_base, wgt_base, ofm_base;
    logic        ifm_req, wgt_req, st_req, ifm_ack, wgt_ack, st_ack;
    logic [31:0] ifm_addr, wgt_addr, st_addr;
    logic        cal_start, done_compute, busy, done, err;
    logic [2:0]  state;
    logic [7:0]  tile_idx;

    logic [EW-1:0] exp_q[$];
    int n_tests = 0, n_fail = 0, cyc = 0;
    int ack_mode = 0, dc_mode = 0, dc_check = 0;
    int wgt_beats = 0, stall_left = 0, stall_cycles = 0, cal_cyc = 0;
    bit stall_armed = 0, stall_chk = 0, st_watch = 0;
    logic [31:0] stall_exp_addr;

    layer_ctrl_tiled #(.TOTAL_PE(PE), .DATA_BYTES(DB), .ADDR_W(32), .CNT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_KERNEL_W(cfg_KERNEL_W), .cfg_IFM_W(cfg_IFM_W), .cfg_IFM_C(cfg_IFM_C),
        .cfg_OFM_W(cfg_OFM_W), .cfg_OFM_C(cfg_OFM_C), .cfg_stride(cfg_stride),
        .ifm_base(ifm_base), .wgt_base(wgt_base), .ofm_base(ofm_base),
        .ifm_req(ifm_req), .ifm_addr(ifm_addr), .ifm_ack(ifm_ack),
        .wgt_req(wgt_req), .wgt_addr(wgt_addr), .wgt_ack(wgt_ack),
        .st_req(st_req), .st_addr(st_addr), .st_ack(st_ack),
        .cal_start(cal_start), .done_compute(done_compute), .busy(busy), .done(done),
        .err(err), .state(state), .tile_idx(tile_idx)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic observe(input logic [EW-1:0] got);
        logic [EW-1:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected: got kind=%0d tile=%0d addr=%0h, expected nothing",
                     got[41:40], got[39:32], got[31:0]);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                n_fail++;
                $display("FAIL beat: got kind=%0d tile=%0d addr=%0h, expected kind=%0d tile=%0d addr=%0h",
                         got[41:40], got[39:32], got[31:0], e[41:40], e[39:32], e[31:0]);
            end
        end
    endtask

    // Reference model: expand one layer start into its full expected stream.
    task automatic model_layer(input int k, iw, ic, ow, oc, s,
                               input logic [31:0] ib, wb, ob);
        int iwords, wwords, owords, nt;
        bit bad;
        bad = 0;
        if (k == 0 || iw == 0 || ic == 0 || ow == 0 || oc == 0 || s == 0) bad = 1;
        else if (k > iw) bad = 1;
        else if (ow != (iw - k) / s + 1) bad = 1;
        if (bad) begin
            exp_q.push_back({2'd3, 8'd0, 32'd2});
            return;
        end
        iwords = (iw * iw * ic + DB - 1) / DB;
        wwords = (k * k * ic * PE + DB - 1) / DB;
        owords = (ow * ow * PE + DB - 1) / DB;
        nt     = (oc + PE - 1) / PE;
        for (int t = 0; t < nt; t++) begin
            if (t == 0)
                for (int i = 0; i < iwords; i++) exp_q.push_back({2'd0, 8'(t), ib + 32'(i)});
            for (int i = 0; i < wwords; i++) exp_q.push_back({2'd1, 8'(t), wb + 32'(t * wwords + i)});
            exp_q.push_back({2'd3, 8'(t), 32'd0});
            for (int i = 0; i < owords; i++) exp_q.push_back({2'd2, 8'(t), ob + 32'(t * owords + i)});
        end
        exp_q.push_back({2'd3, 8'(nt - 1), 32'd1});
    endtask

    task automatic pulse_start(input int k, iw, ic, ow, oc, s, input logic [31:0] ib, wb, ob);
        @(negedge clk);
        cfg_KERNEL_W = 4'(k); cfg_IFM_W = 8'(iw); cfg_IFM_C = 8'(ic);
        cfg_OFM_W = 8'(ow); cfg_OFM_C = 8'(oc); cfg_stride = 2'(s);
        ifm_base = ib; wgt_base = wb; ofm_base = ob;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs so a design that fails to latch them diverges.
        cfg_KERNEL_W = 4'($urandom); cfg_IFM_W = 8'($urandom); cfg_IFM_C = 8'($urandom);
        cfg_OFM_W = 8'($urandom); cfg_OFM_C = 8'($urandom); cfg_stride = 2'($urandom);
        ifm_base = $urandom; wgt_base = $urandom; ofm_base = $urandom;
    endtask

    task automatic run_layer(input int k, iw, ic, ow, oc, s, input logic [31:0] ib, wb, ob);
        wgt_beats = 0;
        model_layer(k, iw, ic, ow, oc, s, ib, wb, ob);
        pulse_start(k, iw, ic, ow, oc, s, ib, wb, ob);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 150000) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 150000) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, "_idle_state"}, 32'(state), 32'd0);
        check({name, "_idle_tile"}, 32'(tile_idx), 32'd0);
    endtask

    task automatic wait_req(input int which, input string name);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < 5000) begin
            @(negedge clk); n++;
            hit = (which == 0) ? ifm_req : (which == 1) ? wgt_req : st_req;
        end
        if (!hit) begin
            n_tests++; n_fail++;
            $display("FAIL %s: got no request within 5000 cycles expected one", name);
        end
    endtask

    // ---------------- ack and compute drivers ----------------
    initial begin
        ifm_ack = 0; wgt_ack = 0; st_ack = 0;
        forever begin
            @(posedge clk); #1;
            if (stall_armed && wgt_req && wgt_beats == 10) begin
                stall_left  = 5;
                stall_armed = 0;
            end
            if (ack_mode == 0) begin
                ifm_ack = 1; wgt_ack = 1; st_ack = 1;
            end else begin
                ifm_ack = 1'($urandom_range(0, 1));
                wgt_ack = 1'($urandom_range(0, 1));
                st_ack  = 1'($urandom_range(0, 1));
            end
            stall_chk = 0;
            if (stall_left > 0) begin
                wgt_ack = 0; stall_left--; stall_chk = 1;
            end
        end
    end

    initial begin
        done_compute = 0;
        forever begin
            @(negedge clk);
            if (dc_mode != 0) done_compute = 1;
            else begin
                done_compute = 0;
                if (cal_start && rst_n) begin
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    done_compute = 1;
                    @(negedge clk);
                    done_compute = 0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int nreq;
        if (rst_n) begin
            nreq = int'(ifm_req) + int'(wgt_req) + int'(st_req);
            if (nreq > 0) begin
                n_tests++;
                if (nreq > 1) begin
                    n_fail++;
                    $display("FAIL req_mutex: got %0d requests high expected at most 1", nreq);
                end
            end
            if (stall_chk) begin
                stall_cycles++;
                check("stall_req", 32'(wgt_req), 32'd1);
                check("stall_addr", wgt_addr, stall_exp_addr);
            end
            if (st_req && st_watch) begin
                st_watch = 0;
                if (dc_check != 0) check("cal_to_store", 32'(cyc - cal_cyc), 32'd2);
            end
            if (ifm_req && ifm_ack) observe({2'd0, tile_idx, ifm_addr});
            if (wgt_req && wgt_ack) begin
                observe({2'd1, tile_idx, wgt_addr});
                wgt_beats++;
            end
            if (st_req && st_ack) observe({2'd2, tile_idx, st_addr});
            if (cal_start) begin
                observe({2'd3, tile_idx, 32'd0});
                cal_cyc  = cyc;
                st_watch = 1;
            end
            if (done) observe({2'd3, tile_idx, 32'd1});
            if (err)  observe({2'd3, tile_idx, 32'd2});
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k, iw, ic, ow, oc, s;
        logic [31:0] wb, ob;
        start = 0; abort = 0;
        cfg_KERNEL_W = 0; cfg_IFM_W = 0; cfg_IFM_C = 0; cfg_OFM_W = 0; cfg_OFM_C = 0;
        cfg_stride = 0; ifm_base = 0; wgt_base = 0; ofm_base = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cal", 32'(cal_start), 32'd0);
        check("rst_ifm_req", 32'(ifm_req), 32'd0);
        check("rst_wgt_req", 32'(wgt_req), 32'd0);
        check("rst_st_req", 32'(st_req), 32'd0);
        check("rst_ifm_addr", ifm_addr, 32'd0);
        check("rst_wgt_addr", wgt_addr, 32'd0);
        check("rst_st_addr", st_addr, 32'd0);
        check("rst_tile", 32'(tile_idx), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;

        // Full single-tile layer, ack always high.
        ack_mode = 0;
        wb = $urandom_range(0, 32'h0fff_ffff);
        ob = $urandom_range(0, 32'h0fff_ffff);
        run_layer(3, 58, 16, 56, 16, 1, 32'd0, wb, ob);
        wait_drain("single_tile");

        // Three tiles: IFM once, weights and stores advance per tile.
        run_layer(3, 58, 16, 56, 40, 1, 32'h100, wb, ob);
        wait_drain("three_tiles");

        // Mismatched OFM_W: CHECK after one edge, err on the next with busy low.
        model_layer(3, 58, 16, 55, 16, 1, 32'd0, wb, ob);
        pulse_start(3, 58, 16, 55, 16, 1, 32'd0, wb, ob);
        check("err_check_state", 32'(state), 32'd1);
        check("err_not_yet", 32'(err), 32'd0);
        @(negedge clk);
        check("err_pulse", 32'(err), 32'd1);
        check("err_state", 32'(state), 32'd0);
        check("err_busy", 32'(busy), 32'd0);
        wait_drain("bad_cfg");

        // Weight ack held low for 5 cycles at beat 10.
        stall_cycles   = 0;
        stall_exp_addr = wb + 32'd10;
        stall_armed    = 1;
        run_layer(3, 8, 4, 6, 16, 1, 32'h40, wb, ob);
        wait_drain("stall");
        check("stall_cycles", 32'(stall_cycles), 32'd5);

        // 75-byte IFM, done_compute held high throughout, extra start during LOAD_W.
        ack_mode = 1; dc_mode = 1; dc_check = 1;
        run_layer(5, 5, 3, 1, 1, 1, 32'h200, wb, ob);
        wait_req(1, "wait_load_w");
        pulse_start(3, 8, 4, 6, 16, 1, 32'h0, 32'h0, 32'h0);
        wait_drain("small_layer");
        dc_mode = 0; dc_check = 0;

        // Randomized configurations, some deliberately invalid.
        for (int r = 0; r < 6; r++) begin
            k  = $urandom_range(1, 5);
            iw = $urandom_range(k, 12);
            s  = $urandom_range(1, 3);
            ow = (iw - k) / s + 1;
            ic = $urandom_range(1, 6);
            oc = $urandom_range(1, 40);
            case ($urandom_range(0, 5))
                0: ow = ow + 1;
                1: s = 0;
                2: k = iw + 1;
                default: ;
            endcase
            run_layer(k, iw, ic, ow, oc, s, $urandom, $urandom, $urandom);
            wait_drain("random");
        end

        // Abort during STORE.
        run_layer(3, 8, 4, 6, 20, 1, 32'h300, wb, ob);
        wait_req(2, "wait_store");
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_st_req", 32'(st_req), 32'd0);
        check("abort_reqs", 32'(ifm_req | wgt_req), 32'd0);
        check("abort_tile", 32'(tile_idx), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (6) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);

        // Reset during LOAD_IFM on a second run.
        run_layer(3, 8, 4, 6, 20, 1, 32'h400, wb, ob);
        wait_req(0, "wait_load_ifm");
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        exp_q.delete();
        check("rstmid_state", 32'(state), 32'd0);
        check("rstmid_reqs", 32'(ifm_req | wgt_req | st_req), 32'd0);
        check("rstmid_ifm_addr", ifm_addr, 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_tile", 32'(tile_idx), 32'd0);
        @(negedge clk) rst_n = 1;
        repeat (10) @(negedge clk);
        check("rstmid_wait_start", 32'(state), 32'd0);

        // Normal operation after reset.
        run_layer(2, 6, 2, 5, 17, 1, 32'h500, wb, ob);
        wait_drain("recovery");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_ctrl_tiled.md
LAYER_CTRL_TILED -- requirements
Module: layer_ctrl_tiled

Interface
REQ-001 SHALL have parameters, one per line:
- TOTAL_PE, default 16, output channels computed per tile.
- DATA_BYTES, default 4, bytes per memory word (power of 2).
- ADDR_W, default 32, address width.
- CNT_W, default 24, beat-counter width.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle layer start pulse.
- abort  in  1  synchronous abort.
- cfg_KERNEL_W  in  4  kernel width.
- cfg_IFM_W  in  8  input feature-map width.
- cfg_IFM_C  in  8  input channels.
- cfg_OFM_W  in  8  output width.
- cfg_OFM_C  in  8  output channels.
- cfg_stride  in  2  stride.
- ifm_base  in  ADDR_W  IFM word base address.
- wgt_base  in  ADDR_W  weight word base address.
- ofm_base  in  ADDR_W  OFM word base address.
- ifm_req / ifm_addr / ifm_ack  out / out / in  1 / ADDR_W / 1  IFM load beat.
- wgt_req / wgt_addr / wgt_ack  out / out / in  1 / ADDR_W / 1  weight load beat.
- st_req / st_addr / st_ack  out / out / in  1 / ADDR_W / 1  OFM store beat.
- cal_start  out  1  compute start pulse.
- done_compute  in  1  compute finished.
- busy  out  1  layer in progress.
- done  out  1  layer complete pulse.
- err  out  1  configuration error pulse.
- state  out  3  current FSM state code.
- tile_idx  out  8  current output-channel tile.

Function
REQ-003 SHALL implement states IDLE=0, CHECK=1, LOAD_IFM=2, LOAD_W=3, CAL=4, STORE=5, NEXT=6, DONE=7; state output SHALL equal the registered state.
REQ-004 IDLE: on start, SHALL latch all cfg_* and base inputs, then enter CHECK; start SHALL be ignored in every other state.
REQ-005 CHECK (1 cycle) SHALL pulse err and return to IDLE if any of the following holds; otherwise it SHALL enter LOAD_IFM:
- any cfg field is 0;
- KERNEL_W > IFM_W;
- OFM_W != floor((IFM_W-KERNEL_W)/stride)+1.
REQ-006 SHALL compute, using ceiling division by DATA_BYTES:
- IFM_WORDS = ceil(IFM_W*IFM_W*IFM_C/DATA_BYTES);
- WGT_WORDS = ceil(KERNEL_W*KERNEL_W*IFM_C*TOTAL_PE/DATA_BYTES);
- OFM_WORDS = ceil(OFM_W*OFM_W*TOTAL_PE/DATA_BYTES);
- NUM_TILES = ceil(OFM_C/TOTAL_PE).
All products SHALL be formed at CNT_W without truncation.
REQ-007 Every beat interface SHALL follow valid/ready rules:
- req held high with a stable addr until ack is sampled high;
- a beat completes on req&&ack;
- at most one req SHALL be high at a time.
REQ-008 LOAD_IFM: ifm_addr = ifm_base + beat count; after beat IFM_WORDS-1 completes, SHALL enter LOAD_W; LOAD_IFM SHALL occur only for tile 0.
REQ-009 LOAD_W: wgt_addr = wgt_base + tile_idx*WGT_WORDS + beat count; after the last beat, SHALL enter CAL.
REQ-010 CAL: cal_start SHALL be high exactly for the first cycle in CAL; SHALL wait for done_compute, sampled from the second CAL cycle onward, then enter STORE.
REQ-011 STORE: st_addr = ofm_base + tile_idx*OFM_WORDS + beat count; after the last beat, SHALL enter NEXT.
REQ-012 NEXT (1 cycle): if tile_idx == NUM_TILES-1, SHALL enter DONE; otherwise SHALL increment tile_idx, clear the beat count, and enter LOAD_W.
REQ-013 DONE SHALL pulse done for 1 cycle, then enter IDLE with tile_idx cleared.
REQ-014 busy SHALL be high in every state except IDLE.
REQ-015 The beat counter SHALL clear on every state entry.
REQ-016 abort SHALL be evaluated in any non-IDLE state and takes priority over all transitions: on the next edge, all reqs drop, state becomes IDLE, tile_idx=0, and no done pulse is produced.
REQ-017 A done_compute in a state other than CAL SHALL be ignored.

Reset
REQ-018 On rst_n low, SHALL immediately set:
- state=IDLE;
- all req, cal_start, busy, done, err = 0;
- all addr outputs = 0, tile_idx = 0;
- counters and latched config cleared.
REQ-019 Reset mid-transfer SHALL drop req without completing the beat; after reset release, the block SHALL wait for start.

Verification
REQ-020 The bench SHALL cover:
- Config IFM_W=58, IFM_C=16, K=3, stride=1, OFM_W=56, OFM_C=16, ack always 1 -> 13456 IFM beats (addr 0..13455), 576 weight beats, one cal_start, 12544 store beats, done at the end, tile_idx stays 0.
- OFM_C=40, same config otherwise -> NUM_TILES=3, weight addr starts wgt_base+0/576/1152, store addr starts ofm_base+0/12544/25088, IFM loaded only once, 3 cal_start pulses.
- OFM_W=55 -> err pulse 2 cycles after start, no req ever asserted, busy low again.
- wgt_ack held low 5 cycles mid-load -> wgt_req and wgt_addr unchanged across those cycles, beat count advances only on ack.
- IFM_W=5, IFM_C=3, K=5, OFM_W=1, OFM_C=1 -> IFM_WORDS=19 (75 bytes rounded up), WGT_WORDS=300; start pulsed during LOAD_W ignored.
- abort asserted in STORE, then rst_n pulsed low in LOAD_IFM on a second run -> each time IDLE on the following edge/immediately, reqs 0, no done.
